// File: rtl/score_pkg.sv
// score_pkg: shared state/grade types and default grade thresholds for score_grader
package score_pkg;
    typedef enum logic [2:0] {IDLE, COLLECT, DIVIDE, GRADE, DONE} grader_state_t;
    typedef logic [1:0] grade_t;
    localparam int DEF_THRESH_3 = 100;
    localparam int DEF_THRESH_2 = 300;
    localparam int DEF_THRESH_1 = 600;
endpackage

// File: rtl/score_div.sv
// score_div: restoring divider, one quotient bit per cycle, WIDTH cycles after start
module score_div #(
    parameter int WIDTH = 32,
    parameter int OUT_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [OUT_WIDTH-1:0] quotient,
    output logic                 done
);
    localparam int SW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [SW-1:0] step;
    logic active;
    logic [WIDTH:0] trial, diff;
    assign trial = {rem, quo[WIDTH-1]};
    assign diff = trial - {1'b0, dvs};
    // done flags the cycle whose edge retires the last quotient bit
    assign done = active && step == SW'(WIDTH - 1);
    assign quotient = quo[OUT_WIDTH-1:0];
    // dividend bits shift out of quo while quotient bits shift in behind them
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            step <= '0;
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (start) begin
            active <= 1'b1;
            step <= '0;
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (active) begin
            rem <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], !diff[WIDTH]};
            step <= step + SW'(1);
            active <= !done;
        end
    end
endmodule

// File: rtl/score_grader.sv
// score_grader: routine mean/best/grade over valid/ready frames; SCORE_GRADER_BEST_EN builds best-frame tracking
module score_grader
    import score_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH = 8,
    parameter int ACC_WIDTH = DATA_WIDTH + CNT_WIDTH,
    parameter int THRESH_3 = DEF_THRESH_3,
    parameter int THRESH_2 = DEF_THRESH_2,
    parameter int THRESH_1 = DEF_THRESH_1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  routine_start,
    input  logic                  routine_end,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] score_in,
    output logic [DATA_WIDTH-1:0] avg_score,
    output logic [DATA_WIDTH-1:0] best_score,
    output logic [1:0]            grade,
    output logic                  overflow,
    output logic                  out_valid,
    output logic                  busy
);
    grader_state_t state;
    logic [ACC_WIDTH-1:0] acc, acc_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic [DATA_WIDTH-1:0] quotient, mean;
    logic ovf, no_frames, clr, take, drop, fin, div_start, div_done;
    grade_t tier;
    assign in_ready = state == COLLECT;
    assign busy = state != IDLE;
    assign clr = routine_start && (state == IDLE || state == COLLECT);
    assign take = in_ready && in_valid && !routine_start && cnt != '1;
    assign drop = in_ready && in_valid && !routine_start && cnt == '1;
    assign acc_nx = take ? acc + ACC_WIDTH'(score_in) : acc;
    assign cnt_nx = take ? cnt + CNT_WIDTH'(1) : cnt;
    assign fin = in_ready && routine_end && !routine_start;
    assign div_start = fin && cnt_nx != '0;
    assign mean = no_frames ? '1 : quotient;
    assign tier = mean < DATA_WIDTH'(THRESH_3) ? 2'd3 :
                  mean < DATA_WIDTH'(THRESH_2) ? 2'd2 :
                  mean < DATA_WIDTH'(THRESH_1) ? 2'd1 : 2'd0;

    score_div #(.WIDTH(ACC_WIDTH), .OUT_WIDTH(DATA_WIDTH)) u_div (
        .clk(clk),
        .rst(rst),
        .start(div_start),
        .dividend(acc_nx),
        .divisor(ACC_WIDTH'(cnt_nx)),
        .quotient(quotient),
        .done(div_done)
    );

    // routine control, accumulation and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            no_frames <= 1'b0;
            avg_score <= '0;
            grade <= '0;
            overflow <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            acc <= clr ? '0 : acc_nx;
            cnt <= clr ? '0 : cnt_nx;
            ovf <= clr ? 1'b0 : ovf | drop;
            no_frames <= fin ? cnt_nx == '0 : no_frames;
            out_valid <= state == GRADE;
            case (state)
                IDLE:    state <= routine_start ? COLLECT : IDLE;
                COLLECT: state <= fin ? (div_start ? DIVIDE : GRADE) : COLLECT;
                DIVIDE:  state <= div_done ? GRADE : DIVIDE;
                GRADE: begin
                    avg_score <= mean;
                    grade <= tier;
                    overflow <= ovf;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCORE_GRADER_BEST_EN
    logic [DATA_WIDTH-1:0] best;
    // minimum accepted frame, published alongside the other results
    always_ff @(posedge clk) begin
        if (rst) begin
            best <= '1;
            best_score <= '0;
        end else begin
            best <= clr ? '1 : (take && score_in < best) ? score_in : best;
            best_score <= state == GRADE ? best : best_score;
        end
    end
`else
    assign best_score = '0;
`endif
endmodule
